// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_arb_pkg
// Purpose : Shared types and constants for the memory port arbiter.
//           arb_state_t - arbiter FSM states
//           gnt_t       - identity of the granted requester
//           IF_BMASK_ALL - all-ones byte mask used for instruction fetches;
//                          sliced to DATA_W/8 bits at the point of use
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_LS = 1'b1
  } gnt_t;

  // Wide enough for any supported data width (up to 512 bits).
  localparam int unsigned            MAX_BMASK_W  = 64;
  localparam logic [MAX_BMASK_W-1:0] IF_BMASK_ALL = '1;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_port_arbiter
// Purpose : Shares one memory port between instruction fetch (IF) and the
//           load/store unit (LSU). Round-robin on ties, registered memory
//           request, bounded wait for mem_ready with sticky timeout error,
//           one-cycle ack per completed access and a core stall output.
// Ports   : i_clk, i_rst_n          clock / async active-low reset
//           if_req/if_addr          fetch request in
//           if_rdata/if_ack         fetch response out
//           ls_req/ls_we/ls_addr/ls_wdata/ls_bmask   LSU request in
//           ls_rdata/ls_ack         LSU response out
//           mem_req/mem_we/mem_addr/mem_wdata/mem_bmask  memory request out
//           mem_rdata/mem_ready     memory response in
//           stall                   core freeze (combinational)
//           err/err_clr             sticky timeout flag and its clear
// Revision: 1.0 - initial release
// ============================================================================
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_ack,
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_bmask,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                ls_ack,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_bmask,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ready,
  output logic                stall,
  output logic                err,
  input  logic                err_clr
);

  localparam int BM_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);
  localparam logic [BM_W-1:0]  IF_BMASK = IF_BMASK_ALL[BM_W-1:0];

  arb_state_t          state_q,     state_d;
  gnt_t                last_gnt_q,  last_gnt_d;
  logic [CNT_W-1:0]    cnt_q,       cnt_d;
  logic                mem_req_q,   mem_req_d;
  logic                mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [BM_W-1:0]     mem_bmask_q, mem_bmask_d;
  logic [DATA_W-1:0]   if_rdata_q,  if_rdata_d;
  logic [DATA_W-1:0]   ls_rdata_q,  ls_rdata_d;
  logic                if_ack_q,    if_ack_d;
  logic                ls_ack_q,    ls_ack_d;
  logic                err_q,       err_d;
  gnt_t                win;
  logic                abort;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      last_gnt_q  <= GNT_IF;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_bmask_q <= '0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
      if_ack_q    <= 1'b0;
      ls_ack_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_gnt_q  <= last_gnt_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_bmask_q <= mem_bmask_d;
      if_rdata_q  <= if_rdata_d;
      ls_rdata_q  <= ls_rdata_d;
      if_ack_q    <= if_ack_d;
      ls_ack_q    <= ls_ack_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    last_gnt_d  = last_gnt_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_bmask_d = mem_bmask_q;
    if_rdata_d  = if_rdata_q;
    ls_rdata_d  = ls_rdata_q;
    if_ack_d    = 1'b0;
    ls_ack_d    = 1'b0;
    abort       = 1'b0;
    win         = GNT_IF;

    case (state_q)
      IDLE: begin
        if (if_req || ls_req) begin
          // Tie goes to whoever did not win last; after reset that is the LSU.
          if (if_req && ls_req) begin
            win = (last_gnt_q == GNT_IF) ? GNT_LS : GNT_IF;
          end else begin
            win = ls_req ? GNT_LS : GNT_IF;
          end
          last_gnt_d = win;
          cnt_d      = '0;
          mem_req_d  = 1'b1;
          if (win == GNT_LS) begin
            mem_we_d    = ls_we;
            mem_addr_d  = ls_addr;
            mem_wdata_d = ls_wdata;
            mem_bmask_d = ls_bmask;
          end else begin
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
            mem_bmask_d = IF_BMASK;
          end
          state_d = BUSY;
        end
      end

      BUSY: begin
        // Ready is checked first so a completion on the last allowed cycle
        // is not reported as a timeout.
        if (mem_ready) begin
          if (last_gnt_q == GNT_LS) begin
            ls_rdata_d = mem_we_q ? '0 : mem_rdata;
            ls_ack_d   = 1'b1;
          end else begin
            if_rdata_d = mem_rdata;
            if_ack_d   = 1'b1;
          end
          mem_req_d = 1'b0;
          state_d   = RESP;
        end else if (cnt_q == CNT_LAST) begin
          abort = 1'b1;
          if (last_gnt_q == GNT_LS) begin
            ls_rdata_d = '0;
            ls_ack_d   = 1'b1;
          end else begin
            if_rdata_d = '0;
            if_ack_d   = 1'b1;
          end
          mem_req_d = 1'b0;
          state_d   = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase

    // A timeout in the same cycle as a clear leaves the flag set.
    if (abort) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_bmask = mem_bmask_q;
  assign if_rdata  = if_rdata_q;
  assign ls_rdata  = ls_rdata_q;
  assign if_ack    = if_ack_q;
  assign ls_ack    = ls_ack_q;
  assign err       = err_q;

  assign stall = (if_req & ~if_ack_q) | (ls_req & ~ls_ack_q);

endmodule : mem_port_arbiter
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_port_arbiter
// Purpose : Directed self-checking bench for mem_port_arbiter (MAX_WAIT=4).
//           Covers reset state, fetch, store with wait states, timeout,
//           abort/clear collision, reset mid-access and tie round-robin.
// Ports   : none
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk;
  logic              rst_n;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;
  logic              ls_req;
  logic              ls_we;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic [3:0]        ls_bmask;
  logic [DATA_W-1:0] ls_rdata;
  logic              ls_ack;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [3:0]        mem_bmask;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic              stall;
  logic              err;
  logic              err_clr;

  int vectors;
  int miscompares;

  mem_port_arbiter #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .MAX_WAIT(4)
  ) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_ack   (if_ack),
    .ls_req   (ls_req),
    .ls_we    (ls_we),
    .ls_addr  (ls_addr),
    .ls_wdata (ls_wdata),
    .ls_bmask (ls_bmask),
    .ls_rdata (ls_rdata),
    .ls_ack   (ls_ack),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_bmask(mem_bmask),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .stall    (stall),
    .err      (err),
    .err_clr  (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst_n = 1'b0; if_req = 1'b0; if_addr = '0;
    ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0; ls_bmask = '0;
    mem_rdata = '0; mem_ready = 1'b0; err_clr = 1'b0;

    // ---- reset state ----
    step(); step();
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_if_ack", 64'(if_ack), 64'd0);
    chk("rst_ls_ack", 64'(ls_ack), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    rst_n = 1'b1;
    step();

    // ---- fetch only ----
    if_req = 1'b1; if_addr = 32'h100;
    step();
    chk("f_mem_req", 64'(mem_req), 64'd1);
    chk("f_mem_addr", 64'(mem_addr), 64'h100);
    chk("f_mem_we", 64'(mem_we), 64'd0);
    chk("f_mem_bmask", 64'(mem_bmask), 64'hF);
    chk("f_mem_wdata", 64'(mem_wdata), 64'd0);
    chk("f_ack_early", 64'(if_ack), 64'd0);
    chk("f_stall", 64'(stall), 64'd1);
    mem_ready = 1'b1; mem_rdata = 32'h00500093;
    step();
    chk("f_if_ack", 64'(if_ack), 64'd1);
    chk("f_if_rdata", 64'(if_rdata), 64'h00500093);
    chk("f_mem_req_drop", 64'(mem_req), 64'd0);
    chk("f_ls_ack", 64'(ls_ack), 64'd0);
    chk("f_stall_ack", 64'(stall), 64'd0);
    mem_ready = 1'b0; if_req = 1'b0;
    step();
    chk("f_ack_once", 64'(if_ack), 64'd0);

    // ---- store with 2 wait states ----
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h2000;
    ls_wdata = 32'hDEADBEEF; ls_bmask = 4'b0011;
    step();
    for (int i = 0; i < 3; i++) begin
      chk("s_mem_req", 64'(mem_req), 64'd1);
      chk("s_mem_we", 64'(mem_we), 64'd1);
      chk("s_mem_addr", 64'(mem_addr), 64'h2000);
      chk("s_mem_wdata", 64'(mem_wdata), 64'hDEADBEEF);
      chk("s_mem_bmask", 64'(mem_bmask), 64'h3);
      chk("s_ls_ack_wait", 64'(ls_ack), 64'd0);
      if (i == 2) begin
        mem_ready = 1'b1; mem_rdata = 32'h12345678;
      end
      step();
    end
    chk("s_ls_ack", 64'(ls_ack), 64'd1);
    chk("s_ls_rdata", 64'(ls_rdata), 64'd0);
    chk("s_if_ack", 64'(if_ack), 64'd0);
    chk("s_if_rdata_hold", 64'(if_rdata), 64'h00500093);
    mem_ready = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
    step();
    chk("s_ack_once", 64'(ls_ack), 64'd0);

    // ---- timeout (MAX_WAIT=4) ----
    if_req = 1'b1; if_addr = 32'h300;
    step();
    for (int i = 0; i < 4; i++) begin
      chk("t_mem_req_high", 64'(mem_req), 64'd1);
      chk("t_no_ack", 64'(if_ack), 64'd0);
      step();
    end
    chk("t_mem_req_drop", 64'(mem_req), 64'd0);
    chk("t_if_ack", 64'(if_ack), 64'd1);
    chk("t_if_rdata", 64'(if_rdata), 64'd0);
    chk("t_err_set", 64'(err), 64'd1);
    if_req = 1'b0;
    step();
    chk("t_err_sticky", 64'(err), 64'd1);
    chk("t_ack_once", 64'(if_ack), 64'd0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("t_err_clr", 64'(err), 64'd0);

    // ---- abort coincident with err_clr ----
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h400;
    step();
    for (int i = 0; i < 4; i++) begin
      chk("c_mem_req_high", 64'(mem_req), 64'd1);
      if (i == 3) err_clr = 1'b1;
      step();
    end
    err_clr = 1'b0;
    chk("c_err_wins", 64'(err), 64'd1);
    chk("c_ls_ack", 64'(ls_ack), 64'd1);
    chk("c_ls_rdata", 64'(ls_rdata), 64'd0);
    ls_req = 1'b0;
    step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("c_err_clr", 64'(err), 64'd0);

    // ---- reset mid-access ----
    // last grant was LSU; the reset must restore IF so the tie goes to LSU.
    if_req = 1'b1; if_addr = 32'h500;
    step();
    chk("r_busy_req", 64'(mem_req), 64'd1);
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h600;
    rst_n = 1'b0;
    #1;
    chk("r_mem_req_async", 64'(mem_req), 64'd0);
    chk("r_mem_addr_async", 64'(mem_addr), 64'd0);
    chk("r_if_ack", 64'(if_ack), 64'd0);
    chk("r_ls_ack", 64'(ls_ack), 64'd0);
    chk("r_stall_in_rst", 64'(stall), 64'd1);
    step();
    rst_n = 1'b1;

    // ---- tie after reset: LS, IF, LS, IF ----
    step();
    chk("rr1_addr", 64'(mem_addr), 64'h600);
    mem_ready = 1'b1; mem_rdata = 32'hAAAA0001;
    step();
    mem_ready = 1'b0;
    chk("rr1_ls_ack", 64'(ls_ack), 64'd1);
    chk("rr1_ls_rdata", 64'(ls_rdata), 64'hAAAA0001);
    chk("rr1_if_ack", 64'(if_ack), 64'd0);
    chk("rr1_stall", 64'(stall), 64'd1);
    step();
    chk("rr1_ack_once", 64'(ls_ack), 64'd0);
    chk("rr1_idle_stall", 64'(stall), 64'd1);
    step();
    chk("rr2_addr", 64'(mem_addr), 64'h500);
    mem_ready = 1'b1; mem_rdata = 32'hBBBB0002;
    step();
    mem_ready = 1'b0;
    chk("rr2_if_ack", 64'(if_ack), 64'd1);
    chk("rr2_if_rdata", 64'(if_rdata), 64'hBBBB0002);
    chk("rr2_ls_ack", 64'(ls_ack), 64'd0);
    chk("rr2_ls_rdata_hold", 64'(ls_rdata), 64'hAAAA0001);
    ls_addr = 32'h604;
    step();
    step();
    chk("rr3_addr", 64'(mem_addr), 64'h604);
    mem_ready = 1'b1; mem_rdata = 32'hCCCC0003;
    step();
    mem_ready = 1'b0;
    chk("rr3_ls_ack", 64'(ls_ack), 64'd1);
    chk("rr3_ls_rdata", 64'(ls_rdata), 64'hCCCC0003);
    ls_req = 1'b0;
    step();
    step();
    chk("rr4_addr", 64'(mem_addr), 64'h500);
    chk("rr4_stall", 64'(stall), 64'd1);
    mem_ready = 1'b1; mem_rdata = 32'hDDDD0004;
    step();
    mem_ready = 1'b0;
    chk("rr4_if_ack", 64'(if_ack), 64'd1);
    chk("rr4_if_rdata", 64'(if_rdata), 64'hDDDD0004);
    chk("rr4_stall_done", 64'(stall), 64'd0);
    if_req = 1'b0;
    step();
    chk("rr4_ack_once", 64'(if_ack), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_mem_port_arbiter
`default_nettype wire
